// File: rtl/stall_sched_if.sv
// Shared memory port handshake between the pipeline scheduler and the port controller.
// Signal names carry the scheduler's view of direction.
interface stall_sched_if;
   logic if_req_i;
   logic mem_req_i;
   logic port_done_i;
   logic port_req_o;
   logic port_sel_o;

   modport master (
      output if_req_i,
      output mem_req_i,
      output port_done_i,
      input  port_req_o,
      input  port_sel_o
   );

   modport slave (
      input  if_req_i,
      input  mem_req_i,
      input  port_done_i,
      output port_req_o,
      output port_sel_o
   );
endinterface

// File: rtl/stall_sched.sv
// Pipeline scheduler: arbitrates the shared memory port (MEM over IF) and drives stage stall codes.
// Optional stall-cycle counter is built when STALL_PERF_CNT_EN is defined.
module stall_sched (
   input  logic         dclk,
   input  logic         rst,
   stall_sched_if.slave port,
   input  logic         ex_load_i,
   input  logic [4:0]   ex_waddr_i,
   input  logic         id_re1_i,
   input  logic         id_re2_i,
   input  logic [4:0]   id_raddr1_i,
   input  logic [4:0]   id_raddr2_i,
   input  logic         ex_branch_i,
   output logic [1:0]   stl_PC_o,
   output logic [1:0]   stl_IFID_o,
   output logic [1:0]   stl_IDEX_o,
   output logic [1:0]   stl_EXMEM_o,
   output logic [1:0]   stl_MEMWB_o
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0]  stall_cycles_o
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] IF_ACC  = 2'd1;
   localparam logic [1:0] MEM_ACC = 2'd2;

   localparam logic [1:0] GO     = 2'b00;
   localparam logic [1:0] STALL  = 2'b01;
   localparam logic [1:0] BUBBLE = 2'b10;

   logic [1:0] state_q, state_d;
   logic       kill_q, kill_d;
   logic       memwait;
   logic       ifdone;
   logic       loaduse;
   logic       branch_take;

   // Port ownership FSM; the mandatory IDLE cycle falls out of returning to IDLE on done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (port.mem_req_i) begin
               state_d = MEM_ACC;
            end else if (port.if_req_i) begin
               state_d = IF_ACC;
            end
         end
         IF_ACC, MEM_ACC: begin
            if (port.port_done_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      memwait = port.mem_req_i && !(state_q == MEM_ACC && port.port_done_i);
      ifdone  = (state_q == IF_ACC) && port.port_done_i;
      loaduse = ex_load_i && (ex_waddr_i != 5'd0) &&
                ((id_re1_i && (id_raddr1_i == ex_waddr_i)) ||
                 (id_re2_i && (id_raddr2_i == ex_waddr_i)));
      // A branch held off by memwait stays asserted and is taken once memwait drops.
      branch_take = ex_branch_i && !memwait;
   end

   // Remember that the in-flight fetch belongs to the wrong path.
   always_comb begin
      kill_d = kill_q;
      if (ifdone) begin
         kill_d = 1'b0;
      end else if (branch_take && (state_q == IF_ACC)) begin
         kill_d = 1'b1;
      end
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   assign port.port_req_o = (state_q != IDLE);
   assign port.port_sel_o = (state_q == MEM_ACC);

   // Stage codes, highest-priority rule first; a fetch completing while IF_ID is not Go is dropped.
   always_comb begin
      stl_PC_o    = STALL;
      stl_IFID_o  = BUBBLE;
      stl_IDEX_o  = GO;
      stl_EXMEM_o = GO;
      stl_MEMWB_o = GO;
      if (rst) begin
         stl_PC_o    = BUBBLE;
         stl_IFID_o  = BUBBLE;
         stl_IDEX_o  = BUBBLE;
         stl_EXMEM_o = BUBBLE;
         stl_MEMWB_o = BUBBLE;
      end else if (memwait) begin
         stl_PC_o    = STALL;
         stl_IFID_o  = STALL;
         stl_IDEX_o  = STALL;
         stl_EXMEM_o = STALL;
         stl_MEMWB_o = BUBBLE;
      end else if (ex_branch_i) begin
         stl_PC_o    = GO;
         stl_IFID_o  = BUBBLE;
         stl_IDEX_o  = BUBBLE;
      end else if (loaduse) begin
         stl_PC_o    = STALL;
         stl_IFID_o  = STALL;
         stl_IDEX_o  = BUBBLE;
      end else if (ifdone && !kill_q) begin
         stl_PC_o    = GO;
         stl_IFID_o  = GO;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else if ((stl_PC_o != GO) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_sched.sv
// Bench for stall_sched: directed vectors with literal expectations plus a per-cycle rule model.
module tb_stall_sched;
   logic       dclk;
   logic       rst;
   logic       ex_load;
   logic [4:0] ex_waddr;
   logic       id_re1;
   logic       id_re2;
   logic [4:0] id_raddr1;
   logic [4:0] id_raddr2;
   logic       ex_branch;
   logic [1:0] stl_pc, stl_ifid, stl_idex, stl_exmem, stl_memwb;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   // Model: who owns the port (0 none, 1 fetch, 2 data), wrong-path flag, stall counter.
   int          m_owner;
   bit          m_kill;
   logic [31:0] m_cnt;

   localparam logic [9:0] RB = 10'b10_10_10_10_10;
   localparam logic [9:0] ST = 10'b01_10_00_00_00;
   localparam logic [9:0] GA = 10'b00_00_00_00_00;
   localparam logic [9:0] LU = 10'b01_01_10_00_00;
   localparam logic [9:0] MW = 10'b01_01_01_01_10;
   localparam logic [9:0] BR = 10'b00_10_10_00_00;

   stall_sched_if pif ();

   stall_sched dut (
      .dclk        (dclk),
      .rst         (rst),
      .port        (pif),
      .ex_load_i   (ex_load),
      .ex_waddr_i  (ex_waddr),
      .id_re1_i    (id_re1),
      .id_re2_i    (id_re2),
      .id_raddr1_i (id_raddr1),
      .id_raddr2_i (id_raddr2),
      .ex_branch_i (ex_branch),
      .stl_PC_o    (stl_pc),
      .stl_IFID_o  (stl_ifid),
      .stl_IDEX_o  (stl_idex),
      .stl_EXMEM_o (stl_exmem),
      .stl_MEMWB_o (stl_memwb)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cycles_o (stall_cycles)
`endif
   );

`ifndef STALL_PERF_CNT_EN
   assign stall_cycles = 32'd0;
`endif

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
      end
   endtask

   function automatic bit mw_now();
      return pif.mem_req_i && !(m_owner == 2 && pif.port_done_i);
   endfunction

   function automatic bit ifdone_now();
      return (m_owner == 1) && pif.port_done_i;
   endfunction

   function automatic logic [9:0] expect_codes();
      bit hz;
      hz = ex_load && (ex_waddr != 5'd0) &&
           ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
      if (mw_now())                  return MW;
      if (ex_branch)                 return BR;
      if (hz)                        return LU;
      if (ifdone_now() && !m_kill)   return GA;
      return ST;
   endfunction

   function automatic logic [1:0] exp_pc();
      logic [9:0] c;
      c = expect_codes();
      return c[9:8];
   endfunction

   always @(posedge dclk or posedge rst) begin
      if (rst) begin
         m_owner <= 0;
         m_kill  <= 1'b0;
         m_cnt   <= 32'd0;
      end else begin
         if (ifdone_now()) m_kill <= 1'b0;
         else if (m_owner == 1 && ex_branch && !mw_now()) m_kill <= 1'b1;
         if (exp_pc() != 2'b00 && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
         if (m_owner == 0) m_owner <= pif.mem_req_i ? 2 : (pif.if_req_i ? 1 : 0);
         else if (pif.port_done_i) m_owner <= 0;
      end
   end

   always @(negedge dclk) begin
      check("model_stl", {22'd0, stl_pc, stl_ifid, stl_idex, stl_exmem, stl_memwb},
            {22'd0, (rst ? RB : expect_codes())});
      check("model_req", {31'd0, pif.port_req_o}, {31'd0, (!rst && m_owner != 0)});
      check("model_sel", {31'd0, pif.port_sel_o}, {31'd0, (!rst && m_owner == 2)});
`ifdef STALL_PERF_CNT_EN
      check("model_cnt", stall_cycles, m_cnt);
`endif
   end

   task automatic step(input string nm, input logic [9:0] c, input logic rq, input logic sl,
                       input int want_cnt);
      @(negedge dclk);
      check({nm, ".stl"}, {22'd0, stl_pc, stl_ifid, stl_idex, stl_exmem, stl_memwb}, {22'd0, c});
      check({nm, ".req"}, {31'd0, pif.port_req_o}, {31'd0, rq});
      check({nm, ".sel"}, {31'd0, pif.port_sel_o}, {31'd0, sl});
`ifdef STALL_PERF_CNT_EN
      if (want_cnt >= 0) check({nm, ".cnt"}, stall_cycles, want_cnt);
`endif
      @(posedge dclk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      pif.if_req_i = 1'b0; pif.mem_req_i = 1'b0; pif.port_done_i = 1'b0;
      ex_load = 1'b0; ex_waddr = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
      id_raddr1 = 5'd0; id_raddr2 = 5'd0; ex_branch = 1'b0;

      step("reset", RB, 1'b0, 1'b0, 0);
      rst = 1'b0; pif.if_req_i = 1'b1;
      step("idle_wait", ST, 1'b0, 1'b0, -1);
      step("if_acc1", ST, 1'b1, 1'b0, -1);
      step("if_acc2", ST, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b1;
      step("if_done", GA, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b0;
      step("gap_idle", ST, 1'b0, 1'b0, -1);
      ex_load = 1'b1; ex_waddr = 5'd5; id_re2 = 1'b1; id_raddr2 = 5'd5;
      step("load_use", LU, 1'b1, 1'b0, -1);
      ex_waddr = 5'd0; id_raddr2 = 5'd0;
      step("load_x0", ST, 1'b1, 1'b0, -1);
      ex_load = 1'b0; id_re2 = 1'b0; pif.mem_req_i = 1'b1;
      step("mem_in_if", MW, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b1;
      step("if_done_discard", MW, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b0;
      step("both_req_idle", MW, 1'b0, 1'b0, -1);
      step("mem_acc", MW, 1'b1, 1'b1, -1);
      pif.port_done_i = 1'b1;
      step("mem_done", ST, 1'b1, 1'b1, -1);
      pif.port_done_i = 1'b0; pif.mem_req_i = 1'b0;
      step("if_after_mem", ST, 1'b0, 1'b0, -1);
      ex_branch = 1'b1;
      step("branch_kill", BR, 1'b1, 1'b0, -1);
      ex_branch = 1'b0;
      step("killed_wait", ST, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b1;
      step("killed_done", ST, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b0;
      step("refetch_idle", ST, 1'b0, 1'b0, -1);
      pif.port_done_i = 1'b1;
      step("refetch_done", GA, 1'b1, 1'b0, -1);
      pif.port_done_i = 1'b0; pif.if_req_i = 1'b0;
      step("quiet", ST, 1'b0, 1'b0, -1);
      pif.port_done_i = 1'b1;
      step("done_in_idle", ST, 1'b0, 1'b0, -1);
      pif.port_done_i = 1'b0; pif.mem_req_i = 1'b1;
      step("mem_req_idle", MW, 1'b0, 1'b0, -1);
      step("mem_acc2", MW, 1'b1, 1'b1, -1);
      rst = 1'b1; pif.mem_req_i = 1'b0;
      step("reset_mid", RB, 1'b0, 1'b0, 0);
      rst = 1'b0; pif.port_done_i = 1'b1;
      ex_load = 1'b1; ex_waddr = 5'd7; id_re1 = 1'b1; id_raddr1 = 5'd7;
      step("late_done", LU, 1'b0, 1'b0, 0);
      pif.port_done_i = 1'b0;
      step("lu2", LU, 1'b0, 1'b0, 1);
      step("lu3", LU, 1'b0, 1'b0, 2);
      step("lu4", LU, 1'b0, 1'b0, 3);
      ex_load = 1'b0; id_re1 = 1'b0; pif.if_req_i = 1'b1;
      step("fw1", ST, 1'b0, 1'b0, 4);
      step("fw2", ST, 1'b1, 1'b0, 5);
      step("fw3", ST, 1'b1, 1'b0, 6);
      pif.port_done_i = 1'b1;
      step("cnt7", GA, 1'b1, 1'b0, 7);
      pif.port_done_i = 1'b0; pif.if_req_i = 1'b0;
      step("cnt_hold", ST, 1'b0, 1'b0, 7);
      rst = 1'b1;
      step("cnt_rst", RB, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
